// File: rtl/lcd_nibble_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_nibble_ctrl
//
// HD44780-style character-LCD engine for a 7-pin 4-bit LCD header. It drives
// the per-pin O/T signals of the LCD_GPIO IOBUF bank directly.
//
// After reset the block waits for the LCD to power up. It then sends the
// 4-bit entry sequence (nibbles 3, 3, 3, 2), each nibble followed by a fixed
// wait. Once this is done the block accepts whole command/data bytes over a
// valid/ready port. Each byte is sent as a high nibble and then a low nibble.
// The block then honours the controller's execution time before it accepts
// the next byte. Function-set, display-on and similar setup are left to
// software.
//
// Nibble phase, shared by every nibble written or read:
//   setup  : RS/RW/DB presented, E = 0      (T_SETUP_CYC cycles)
//   high   : E = 1                          (T_E_HIGH_CYC cycles)
//   low    : E = 0, RS/RW/DB held           (T_E_LOW_CYC cycles)
//
// Optional feature, macro LCD_BUSY_POLL_EN:
//   defined   - after each byte the block polls the busy flag instead of
//               using a fixed delay. Each read is two nibble phases with
//               DB released (lcd_tri_t[3:0] = F), RW = 1 and RS = 0. DB7 is
//               sampled on the last E-high cycle of the first phase. Polling
//               gives up after T_CLEAR_CYC cycles. The init waits stay fixed.
//   undefined - fixed delays only. lcd_tri_t is constant 0, RW is constant 0
//               and lcd_tri_i is ignored.
//
// Ports:
//   CLK        in   1  block clock
//   RESET_N    in   1  asynchronous active-low reset
//   s_valid    in   1  byte request
//   s_ready    out  1  block can accept a byte (IDLE and init done)
//   s_rs       in   1  0 = command, 1 = data
//   s_data     in   8  byte to write
//   init_done  out  1  power-up sequence complete; stays high until reset
//   busy       out  1  high whenever the engine is not IDLE
//   lcd_tri_o  out  7  pin drive: [3:0] DB4..DB7, [4] RW, [5] RS, [6] E
//   lcd_tri_t  out  7  tristate control, 1 = input
//   lcd_tri_i  in   7  pin sample (busy-flag polling only)
//
// Every delay counter reloads with (T - 1) and counts down to zero, so each
// T_* value is the exact number of cycles spent in that phase. T = 0 is
// illegal. CNT_W must hold the largest T_* value.
// ---------------------------------------------------------------------------
module lcd_nibble_ctrl #(
    parameter int T_POWERUP_CYC   = 1500000,
    parameter int T_INIT_WAIT_CYC = 410000,
    parameter int T_SETUP_CYC     = 8,
    parameter int T_E_HIGH_CYC    = 50,
    parameter int T_E_LOW_CYC     = 50,
    parameter int T_EXEC_CYC      = 4000,
    parameter int T_CLEAR_CYC     = 160000,
    parameter int CNT_W           = 24
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_rs,
    input  logic [7:0] s_data,
    output logic       init_done,
    output logic       busy,
    output logic [6:0] lcd_tri_o,
    output logic [6:0] lcd_tri_t,
    input  logic [6:0] lcd_tri_i
);

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT_NIB,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_NIB_HI,
        ST_NIB_LO,
        ST_EXEC_WAIT,
        ST_RD_HI,
        ST_RD_LO
    } state_t;

    typedef enum logic [1:0] {
        SUB_SETUP,
        SUB_HIGH,
        SUB_LOW
    } sub_t;

    localparam logic [CNT_W-1:0] L_PWRUP     = CNT_W'(T_POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] L_INIT_WAIT = CNT_W'(T_INIT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] L_SETUP     = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] L_E_HIGH    = CNT_W'(T_E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] L_E_LOW     = CNT_W'(T_E_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] L_CLEAR     = CNT_W'(T_CLEAR_CYC - 1);
`ifndef LCD_BUSY_POLL_EN
    localparam logic [CNT_W-1:0] L_EXEC      = CNT_W'(T_EXEC_CYC - 1);
`endif

    // Registered state
    state_t           r_state;
    sub_t             r_sub;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_init_idx;
    logic             r_init_done;
    logic             r_rs;
    logic [7:0]       r_data;
    logic [6:0]       r_lcd_o;
`ifdef LCD_BUSY_POLL_EN
    logic             r_bf;
    logic [CNT_W-1:0] r_tmo;
    logic [6:0]       r_lcd_t;
`endif

    // Next-state values
    state_t           w_state_next;
    sub_t             w_sub_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_init_idx_next;
    logic             w_init_done_next;
    logic             w_rs_next;
    logic [7:0]       w_data_next;
    logic [6:0]       w_lcd_o_next;
    logic             w_phase_done;
    logic             w_cnt_zero;
    logic             w_accept;
`ifdef LCD_BUSY_POLL_EN
    logic             w_bf_next;
    logic [CNT_W-1:0] w_tmo_next;
    logic [6:0]       w_lcd_t_next;
`else
    logic             w_is_clear;
`endif

    // Pin image for a given engine position. It is evaluated on the *next*
    // state and registered, so E and the data lines come straight from flops.
    // They are then glitch-free and line up cycle-for-cycle with the state.
    function automatic logic [6:0] pin_drive(
        input state_t     st,
        input sub_t       sb,
        input logic [1:0] idx,
        input logic       rs,
        input logic [7:0] d
    );
        logic       e;
        logic [6:0] p;
        e = (sb == SUB_HIGH);
        case (st)
            ST_INIT_NIB: p = {e, 1'b0, 1'b0, (idx == 2'd3) ? 4'h2 : 4'h3};
            ST_NIB_HI:   p = {e, rs, 1'b0, d[7:4]};
            ST_NIB_LO:   p = {e, rs, 1'b0, d[3:0]};
`ifdef LCD_BUSY_POLL_EN
            ST_RD_HI,
            ST_RD_LO:    p = {e, 1'b0, 1'b1, 4'h0};
`endif
            default:     p = 7'h00;
        endcase
        return p;
    endfunction

    assign w_cnt_zero = (r_cnt == '0);
    assign s_ready    = (r_state == ST_IDLE) && r_init_done;
    assign w_accept   = s_valid && s_ready;
    assign init_done  = r_init_done;
    assign busy       = (r_state != ST_IDLE);
    assign lcd_tri_o  = r_lcd_o;

`ifdef LCD_BUSY_POLL_EN
    // Only DB7 carries the busy flag; the other pin samples are not needed.
    logic w_unused_tri_i;
    assign w_unused_tri_i = ^{lcd_tri_i[6:4], lcd_tri_i[2:0]};
    assign lcd_tri_t      = r_lcd_t;
`else
    logic w_unused_tri_i;
    assign w_unused_tri_i = ^lcd_tri_i;
    assign lcd_tri_t      = 7'h00;
    // Clear display and return home (0x02 and its alias 0x03) need the long wait.
    assign w_is_clear     = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) ||
                                      (r_data == 8'h03));
`endif

    // Next-state logic
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        w_state_next     = r_state;
        w_sub_next       = r_sub;
        w_cnt_next       = r_cnt;
        w_init_idx_next  = r_init_idx;
        w_init_done_next = r_init_done;
        w_rs_next        = r_rs;
        w_data_next      = r_data;
        w_phase_done     = 1'b0;
`ifdef LCD_BUSY_POLL_EN
        w_bf_next        = r_bf;
        w_tmo_next       = r_tmo;
`endif

        case (r_state)
            // The counter resets to 0, so the power-up wait counts up to
            // (T-1). This gives the same T cycles as a reload would.
            ST_PWRUP: begin
                if (r_cnt == L_PWRUP) begin
                    w_state_next = ST_INIT_NIB;
                    w_sub_next   = SUB_SETUP;
                    w_cnt_next   = L_SETUP;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            ST_INIT_NIB,
`ifdef LCD_BUSY_POLL_EN
            ST_RD_HI,
            ST_RD_LO,
`endif
            ST_NIB_HI,
            ST_NIB_LO: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else begin
                    case (r_sub)
                        SUB_SETUP: begin
                            w_sub_next = SUB_HIGH;
                            w_cnt_next = L_E_HIGH;
                        end
                        SUB_HIGH: begin
                            w_sub_next = SUB_LOW;
                            w_cnt_next = L_E_LOW;
`ifdef LCD_BUSY_POLL_EN
                            // Last E-high cycle of the first read phase: DB7 = BF.
                            if (r_state == ST_RD_HI) begin
                                w_bf_next = lcd_tri_i[3];
                            end
`endif
                        end
                        default: w_phase_done = 1'b1;
                    endcase
                end
            end

            ST_INIT_WAIT: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else if (r_init_idx == 2'd3) begin
                    w_state_next     = ST_IDLE;
                    w_init_done_next = 1'b1;
                end else begin
                    w_init_idx_next = r_init_idx + 2'd1;
                    w_state_next    = ST_INIT_NIB;
                    w_sub_next      = SUB_SETUP;
                    w_cnt_next      = L_SETUP;
                end
            end

            ST_IDLE: begin
                if (w_accept) begin
                    w_rs_next    = s_rs;
                    w_data_next  = s_data;
                    w_state_next = ST_NIB_HI;
                    w_sub_next   = SUB_SETUP;
                    w_cnt_next   = L_SETUP;
                end
            end

            ST_EXEC_WAIT: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else begin
                    w_state_next = ST_IDLE;
                end
            end

            default: w_state_next = ST_PWRUP;
        endcase

        // End of a nibble phase: by default the next nibble starts in setup.
        if (w_phase_done) begin
            w_sub_next = SUB_SETUP;
            w_cnt_next = L_SETUP;
            case (r_state)
                ST_INIT_NIB: begin
                    w_state_next = ST_INIT_WAIT;
                    w_cnt_next   = L_INIT_WAIT;
                end
                ST_NIB_HI: w_state_next = ST_NIB_LO;
`ifdef LCD_BUSY_POLL_EN
                ST_NIB_LO: begin
                    w_state_next = ST_RD_HI;
                    w_tmo_next   = L_CLEAR;
                end
                ST_RD_HI: w_state_next = ST_RD_LO;
                ST_RD_LO: w_state_next = r_bf ? ST_RD_HI : ST_IDLE;
`else
                ST_NIB_LO: begin
                    w_state_next = ST_EXEC_WAIT;
                    w_cnt_next   = w_is_clear ? L_CLEAR : L_EXEC;
                end
`endif
                default: ;
            endcase
        end

`ifdef LCD_BUSY_POLL_EN
        // The poll timeout covers the whole polling window. It wins over
        // any read that is still in progress.
        if ((r_state == ST_RD_HI) || (r_state == ST_RD_LO)) begin
            if (r_tmo == '0) begin
                w_state_next = ST_IDLE;
            end else begin
                w_tmo_next = r_tmo - CNT_W'(1);
            end
        end
`endif
    end

    assign w_lcd_o_next = pin_drive(w_state_next, w_sub_next, w_init_idx_next,
                                    w_rs_next, w_data_next);
`ifdef LCD_BUSY_POLL_EN
    assign w_lcd_t_next = ((w_state_next == ST_RD_HI) || (w_state_next == ST_RD_LO))
                          ? 7'h0F : 7'h00;
`endif

    // State register. The asynchronous reset drops E at once and discards
    // any byte in flight. The init sequence then reruns from PWRUP.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_PWRUP;
            r_sub       <= SUB_SETUP;
            r_cnt       <= '0;
            r_init_idx  <= 2'd0;
            r_init_done <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_lcd_o     <= 7'h00;
`ifdef LCD_BUSY_POLL_EN
            r_bf        <= 1'b0;
            r_tmo       <= '0;
            r_lcd_t     <= 7'h00;
`endif
        end else begin
            // NOTE: non-blocking assignments here, so every register updates
            // from the same pre-edge values no matter the statement order.
            r_state     <= w_state_next;
            r_sub       <= w_sub_next;
            r_cnt       <= w_cnt_next;
            r_init_idx  <= w_init_idx_next;
            r_init_done <= w_init_done_next;
            r_rs        <= w_rs_next;
            r_data      <= w_data_next;
            r_lcd_o     <= w_lcd_o_next;
`ifdef LCD_BUSY_POLL_EN
            r_bf        <= w_bf_next;
            r_tmo       <= w_tmo_next;
            r_lcd_t     <= w_lcd_t_next;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_nibble_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_nibble_ctrl
//
// Self-checking bench for lcd_nibble_ctrl with short timing values.
// The expected nibbles go into a queue when stimulus is driven. A pin
// monitor pops them on each rising edge of E. It then checks the pins during
// the E-high and E-low-hold windows and checks the E-high width. Each
// scenario task checks the handshake timing inline.
// ---------------------------------------------------------------------------
module tb_lcd_nibble_ctrl;

    localparam int T_POWERUP   = 100;
    localparam int T_INIT_WAIT = 50;
    localparam int T_SETUP     = 2;
    localparam int T_E_HIGH    = 4;
    localparam int T_E_LOW     = 4;
    localparam int T_EXEC      = 20;
    localparam int T_CLEAR     = 60;
    localparam int NIB_CYC     = T_SETUP + T_E_HIGH + T_E_LOW;
    localparam int INIT_CYC    = T_POWERUP + 4 * (NIB_CYC + T_INIT_WAIT);

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_rs = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       init_done;
    logic       busy;
    logic [6:0] lcd_tri_o;
    logic [6:0] lcd_tri_t;
    logic [6:0] lcd_tri_i;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [3:0] db;
        logic [3:0] t;
    } nib_t;

    nib_t exp_q[$];

    // Busy-flag model: DB7 reads 1 for the first busy_reads read pairs.
    int rd_rises   = 0;
    int busy_reads = 0;
    assign lcd_tri_i = {3'b000, (((rd_rises + 1) / 2) <= busy_reads), 3'b000};

    always #5 CLK = ~CLK;

    lcd_nibble_ctrl #(
        .T_POWERUP_CYC   (T_POWERUP),
        .T_INIT_WAIT_CYC (T_INIT_WAIT),
        .T_SETUP_CYC     (T_SETUP),
        .T_E_HIGH_CYC    (T_E_HIGH),
        .T_E_LOW_CYC     (T_E_LOW),
        .T_EXEC_CYC      (T_EXEC),
        .T_CLEAR_CYC     (T_CLEAR),
        .CNT_W           (24)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_rs      (s_rs),
        .s_data    (s_data),
        .init_done (init_done),
        .busy      (busy),
        .lcd_tri_o (lcd_tri_o),
        .lcd_tri_t (lcd_tri_t),
        .lcd_tri_i (lcd_tri_i)
    );

    // Pin monitor, sampled on the falling clock edge
    logic prev_e    = 1'b0;
    int   hi_len    = 0;
    int   hold_left = 0;
    nib_t cur       = '0;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            prev_e    = 1'b0;
            hi_len    = 0;
            hold_left = 0;
        end else begin
            if (lcd_tri_o[6] && !prev_e) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_e_pulse: got rs=%0b rw=%0b db=%h, required no E pulse",
                             lcd_tri_o[5], lcd_tri_o[4], lcd_tri_o[3:0]);
                    cur = {lcd_tri_o[5:0], lcd_tri_t[3:0]};
                end else begin
                    cur = exp_q.pop_front();
                end
                hi_len = 1;
                if (lcd_tri_o[4]) rd_rises++;
            end else if (lcd_tri_o[6]) begin
                hi_len++;
            end else if (prev_e) begin
                n_checks++;
                if (hi_len !== T_E_HIGH) begin
                    n_errors++;
                    $display("FAIL e_width: got %0d cycles, required %0d", hi_len, T_E_HIGH);
                end
                hold_left = T_E_LOW;
            end
            if (lcd_tri_o[6] || hold_left > 0) begin
                n_checks++;
                if ({lcd_tri_o[5:0], lcd_tri_t[3:0]} !== cur) begin
                    n_errors++;
                    $display("FAIL nibble_pins: got rs=%0b rw=%0b db=%h t=%h, required rs=%0b rw=%0b db=%h t=%h",
                             lcd_tri_o[5], lcd_tri_o[4], lcd_tri_o[3:0], lcd_tri_t[3:0],
                             cur.rs, cur.rw, cur.db, cur.t);
                end
                if (!lcd_tri_o[6]) hold_left--;
            end
            prev_e = lcd_tri_o[6];
        end
    end

    // Releases reset and measures the cycles until init_done rises.
    task automatic run_init(output int n);
        nib_t nb;
        for (int i = 0; i < 4; i++) begin
            nb = {1'b0, 1'b0, (i == 3) ? 4'h2 : 4'h3, 4'h0};
            exp_q.push_back(nb);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        n = 0;
        while (!init_done && n < 2000) begin
            @(posedge CLK);
            #1;
            n++;
        end
    endtask

    // Writes one byte. Returns how many cycles s_ready stayed low after the accept.
    task automatic send_byte(input logic rs, input logic [7:0] d, input int rd_pairs,
                             output int low);
        int   guard;
        nib_t nb;
        guard = 0;
        @(negedge CLK);
        while (!s_ready && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got s_ready=%0b, required 1", s_ready);
        end
        s_rs    = rs;
        s_data  = d;
        s_valid = 1'b1;
        nb = {rs, 1'b0, d[7:4], 4'h0}; exp_q.push_back(nb);
        nb = {rs, 1'b0, d[3:0], 4'h0}; exp_q.push_back(nb);
        for (int i = 0; i < 2 * rd_pairs; i++) begin
            nb = {1'b0, 1'b1, 4'h0, 4'hF};
            exp_q.push_back(nb);
        end
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        low = 0;
        while (!s_ready && low < 2000) begin
            @(posedge CLK);
            #1;
            low++;
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({lcd_tri_o, lcd_tri_t, s_ready, init_done, busy} !== {7'h00, 7'h00, 1'b0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_values: got o=%h t=%h ready=%0b done=%0b busy=%0b, required o=00 t=00 ready=0 done=0 busy=1",
                     lcd_tri_o, lcd_tri_t, s_ready, init_done, busy);
        end
        run_init(n);
        n_checks++;
        if (n !== INIT_CYC) begin
            n_errors++;
            $display("FAIL init_latency: got %0d cycles, required %0d", n, INIT_CYC);
        end
        n_checks++;
        if ({s_ready, busy, lcd_tri_o} !== {1'b1, 1'b0, 7'h00}) begin
            n_errors++;
            $display("FAIL idle_after_init: got ready=%0b busy=%0b o=%h, required ready=1 busy=0 o=00",
                     s_ready, busy, lcd_tri_o);
        end
    endtask

    task automatic test_byte_write();
        int low;
        send_byte(1'b1, 8'h41, 0, low);
        n_checks++;
        if (low !== 2 * NIB_CYC + T_EXEC) begin
            n_errors++;
            $display("FAIL data_ready_low: got %0d cycles, required %0d", low, 2 * NIB_CYC + T_EXEC);
        end
    endtask

    task automatic test_clear_home();
        logic [8:0] stim [6];
        int         want [6];
        int         low;
        stim[0] = {1'b0, 8'h01}; want[0] = 2 * NIB_CYC + T_CLEAR;
        stim[1] = {1'b0, 8'h02}; want[1] = 2 * NIB_CYC + T_CLEAR;
        stim[2] = {1'b0, 8'h03}; want[2] = 2 * NIB_CYC + T_CLEAR;
        stim[3] = {1'b0, 8'h04}; want[3] = 2 * NIB_CYC + T_EXEC;
        stim[4] = {1'b1, 8'h01}; want[4] = 2 * NIB_CYC + T_EXEC;
        stim[5] = {1'b0, 8'h00}; want[5] = 2 * NIB_CYC + T_EXEC;
        for (int i = 0; i < 6; i++) begin
            send_byte(stim[i][8], stim[i][7:0], 0, low);
            n_checks++;
            if (low !== want[i]) begin
                n_errors++;
                $display("FAIL exec_wait rs=%0b data=%h: got %0d cycles, required %0d",
                         stim[i][8], stim[i][7:0], low, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   g;
        int   t_acc [3];
        nib_t nb;
        cyc = 0;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            s_rs    = 1'b1;
            s_data  = 8'h30 + 8'(k * 17);
            s_valid = 1'b1;
            g = 0;
            while (!s_ready && g < 200) begin
                @(negedge CLK);
                cyc++;
                g++;
            end
            t_acc[k] = cyc;
            nb = {1'b1, 1'b0, s_data[7:4], 4'h0}; exp_q.push_back(nb);
            nb = {1'b1, 1'b0, s_data[3:0], 4'h0}; exp_q.push_back(nb);
            @(posedge CLK);
            #1;
        end
        s_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            n_checks++;
            if (t_acc[k] - t_acc[k-1] !== 2 * NIB_CYC + T_EXEC + 1) begin
                n_errors++;
                $display("FAIL b2b_spacing %0d: got %0d cycles, required %0d",
                         k, t_acc[k] - t_acc[k-1], 2 * NIB_CYC + T_EXEC + 1);
            end
        end
        g = 0;
        while (!s_ready && g < 200) begin
            @(posedge CLK);
            #1;
            g++;
        end
    endtask

    task automatic test_ignored_valid();
        nib_t nb;
        int   g;
        @(negedge CLK);
        s_rs    = 1'b1;
        s_data  = 8'h55;
        s_valid = 1'b1;
        nb = {1'b1, 1'b0, 4'h5, 4'h0}; exp_q.push_back(nb); exp_q.push_back(nb);
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        repeat (2 * NIB_CYC + 2) @(posedge CLK);
        #1;
        // Execution wait: a request now must not start any pin activity.
        s_data  = 8'hAA;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            n_checks++;
            if ({lcd_tri_o[6], s_ready} !== 2'b00) begin
                n_errors++;
                $display("FAIL valid_while_busy: got e=%0b ready=%0b, required e=0 ready=0",
                         lcd_tri_o[6], s_ready);
            end
        end
        s_valid = 1'b0;
        g = 0;
        while (!s_ready && g < 200) begin
            @(posedge CLK);
            #1;
            g++;
        end
        repeat (15) @(posedge CLK);
        #1;
        n_checks++;
        if ({busy, lcd_tri_o} !== {1'b0, 7'h00}) begin
            n_errors++;
            $display("FAIL no_late_accept: got busy=%0b o=%h, required busy=0 o=00", busy, lcd_tri_o);
        end
    endtask

    task automatic test_reset_mid();
        nib_t nb;
        int   rises;
        int   g;
        int   n;
        logic pe;
        @(negedge CLK);
        s_rs    = 1'b1;
        s_data  = 8'h6C;
        s_valid = 1'b1;
        nb = {1'b1, 1'b0, 4'h6, 4'h0}; exp_q.push_back(nb);
        nb = {1'b1, 1'b0, 4'hC, 4'h0}; exp_q.push_back(nb);
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        rises = 0;
        g     = 0;
        pe    = 1'b0;
        while (rises < 2 && g < 200) begin
            @(posedge CLK);
            #1;
            if (lcd_tri_o[6] && !pe) rises++;
            pe = lcd_tri_o[6];
            g++;
        end
        // Second E pulse (the low nibble) is now high; pull reset mid-pulse.
        #2;
        RESET_N = 1'b0;
        #1;
        n_checks++;
        if ({lcd_tri_o, lcd_tri_t, s_ready, init_done, busy} !== {7'h00, 7'h00, 1'b0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_mid_values: got o=%h t=%h ready=%0b done=%0b busy=%0b, required o=00 t=00 ready=0 done=0 busy=1",
                     lcd_tri_o, lcd_tri_t, s_ready, init_done, busy);
        end
        exp_q.delete();
        repeat (3) @(posedge CLK);
        run_init(n);
        n_checks++;
        if (n !== INIT_CYC) begin
            n_errors++;
            $display("FAIL reinit_latency: got %0d cycles, required %0d", n, INIT_CYC);
        end
    endtask

`ifdef LCD_BUSY_POLL_EN
    task automatic test_busy_poll();
        int low;
        rd_rises   = 0;
        busy_reads = 1;
        send_byte(1'b1, 8'h41, 2, low);
        n_checks++;
        if (low !== 2 * NIB_CYC + 2 * (2 * NIB_CYC)) begin
            n_errors++;
            $display("FAIL poll_ready_low: got %0d cycles, required %0d", low, 6 * NIB_CYC);
        end
        n_checks++;
        if ({lcd_tri_t, lcd_tri_o[4]} !== 8'h00) begin
            n_errors++;
            $display("FAIL poll_restore: got t=%h rw=%0b, required t=00 rw=0", lcd_tri_t, lcd_tri_o[4]);
        end
        rd_rises   = 0;
        busy_reads = 1000;
        send_byte(1'b0, 8'h01, 3, low);
        n_checks++;
        if (low !== 2 * NIB_CYC + T_CLEAR) begin
            n_errors++;
            $display("FAIL poll_timeout: got %0d cycles, required %0d", low, 2 * NIB_CYC + T_CLEAR);
        end
        busy_reads = 0;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef LCD_BUSY_POLL_EN
        test_busy_poll();
`else
        test_byte_write();
        test_clear_home();
        test_back_to_back();
        test_ignored_valid();
`endif
        test_reset_mid();
        repeat (5) @(posedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending nibbles, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
